// File: rtl/layer_driver_8_8_20_if.sv
// Streaming link between the layer driver and the layer it feeds:
// the tx side carries input-vector words, the rx side returns result words.
interface layer_driver_8_8_20_if #(
  parameter int T = 20
);
  logic signed [T-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic signed [T-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/layer_driver_8_8_20.sv
// Layer driver: streams an N-word input vector from a host-loaded buffer into a
// layer, then collects M result words into a host-readable buffer.
module layer_driver_8_8_20 #(
  parameter int N    = 8,
  parameter int M    = 8,
  parameter int T    = 20,
  parameter int LOGN = 3,
  parameter int LOGM = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                host_we,
  input  logic [LOGN-1:0]     host_waddr,
  input  logic signed [T-1:0] host_wdata,
  input  logic [LOGM-1:0]     host_raddr,
  output logic signed [T-1:0] host_rdata,
  output logic                busy,
  output logic                done,
  layer_driver_8_8_20_if.master lyr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [LOGN-1:0] TX_LAST = LOGN'(N - 1);
  localparam logic [LOGN-1:0] TX_ONE  = LOGN'(1);
  localparam logic [LOGM-1:0] RX_LAST = LOGM'(M - 1);
  localparam logic [LOGM-1:0] RX_ONE  = LOGM'(1);

  state_t              state_r;
  logic [LOGN-1:0]     tx_idx_r;
  logic [LOGM-1:0]     rx_cnt_r;
  logic                tx_valid_r;
  logic                rx_ready_r;
  logic                busy_r;
  logic                done_r;
  logic signed [T-1:0] host_rdata_r;
  logic signed [T-1:0] xbuf_r [N];
  logic signed [T-1:0] ybuf_r [M];
  logic                host_wr_ok_s;
  logic                rx_accept_s;

  assign host_wr_ok_s = host_we && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign rx_accept_s  = rx_ready_r && lyr.rx_valid;

  // tx_data follows the registered index so it holds steady through a stall
  assign lyr.tx_data  = xbuf_r[tx_idx_r];
  assign lyr.tx_valid = tx_valid_r;
  assign lyr.rx_ready = rx_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign host_rdata   = host_rdata_r;

  // Run sequencer: state, indices and all handshake/status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      tx_idx_r   <= '0;
      rx_cnt_r   <= '0;
      tx_valid_r <= 1'b0;
      rx_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r    <= ST_SEND;
            tx_idx_r   <= '0;
            rx_cnt_r   <= '0;
            tx_valid_r <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SEND: begin
          if (tx_valid_r && lyr.tx_ready) begin
            if (tx_idx_r == TX_LAST) begin
              state_r    <= ST_RECV;
              tx_valid_r <= 1'b0;
              rx_ready_r <= 1'b1;
            end else begin
              tx_idx_r <= tx_idx_r + TX_ONE;
            end
          end else begin
            tx_idx_r <= tx_idx_r;
          end
        end
        ST_RECV: begin
          if (rx_accept_s) begin
            if (rx_cnt_r == RX_LAST) begin
              state_r    <= ST_DONE;
              rx_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              rx_cnt_r <= rx_cnt_r + RX_ONE;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          tx_valid_r <= 1'b0;
          rx_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // Input buffer: host writes only while no run is in flight; never cleared
  always_ff @(posedge clk) begin
    if (host_wr_ok_s) begin
      xbuf_r[host_waddr] <= host_wdata;
    end
  end

  // Result buffer: filled from accepted layer words; never cleared
  always_ff @(posedge clk) begin
    if (reset && rx_accept_s) begin
      ybuf_r[rx_cnt_r] <= lyr.rx_data;
    end
  end

  // Registered host read port; same-cycle write to the entry returns the old word
  always_ff @(posedge clk) begin
    if (!reset) begin
      host_rdata_r <= '0;
    end else begin
      host_rdata_r <= ybuf_r[host_raddr];
    end
  end

endmodule

// File: tb/tb_layer_driver_8_8_20.sv
// Directed bench for layer_driver_8_8_20: load, send with stalls, receive with
// gaps, mid-run reset, and back-to-back runs, all against hand-computed values.
module tb_layer_driver_8_8_20;

  localparam int N = 8;
  localparam int M = 8;
  localparam int T = 20;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                host_we = 1'b0;
  logic [2:0]          host_waddr = 3'd0;
  logic signed [T-1:0] host_wdata = '0;
  logic [2:0]          host_raddr = 3'd0;
  logic signed [T-1:0] host_rdata;
  logic                busy;
  logic                done;

  int total = 0;
  int bad   = 0;

  logic signed [T-1:0] xexp [N];
  logic signed [T-1:0] yexp [M];
  logic signed [T-1:0] yold [M];

  layer_driver_8_8_20_if #(.T(T)) lyr ();

  layer_driver_8_8_20 #(.N(N), .M(M), .T(T), .LOGN(3), .LOGM(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata),
    .busy       (busy),
    .done       (done),
    .lyr        (lyr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_txv"}, lyr.tx_valid, 0);
    chk({tag, "_rxr"}, lyr.rx_ready, 0);
    chk({tag, "_rdata"}, host_rdata, 0);
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
  endtask

  // Walk SEND: optional stall at stall_at, optional disturbance at index 1
  task automatic send_all(input int stall_at, input int stall_len, input bit disturb);
    lyr.tx_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == stall_at) begin
        lyr.tx_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          chk("stall_txv", lyr.tx_valid, 1);
          chk("stall_txd", lyr.tx_data, xexp[i]);
        end
        lyr.tx_ready = 1'b1;
      end
      chk("send_txv", lyr.tx_valid, 1);
      chk("send_txd", lyr.tx_data, xexp[i]);
      chk("send_rxr", lyr.rx_ready, 0);
      if (disturb && i == 1) begin
        start       = 1'b1;
        host_we     = 1'b1;
        host_waddr  = 3'd0;
        host_wdata  = 20'sd999;
        lyr.rx_valid = 1'b1;
        lyr.rx_data  = 20'sd555;
      end
      step();
      start        = 1'b0;
      host_we      = 1'b0;
      lyr.rx_valid = 1'b0;
    end
    chk("sent_txv", lyr.tx_valid, 0);
    chk("sent_rxr", lyr.rx_ready, 1);
    chk("sent_busy", busy, 1);
  endtask

  // Walk RECV with a valid gap before every odd word; stop_at<0 runs to DONE
  task automatic recv_all(input int stop_at, input bit track);
    for (int k = 0; k < M; k++) begin
      if (k == stop_at) return;
      if (k % 2 == 1) begin
        lyr.rx_valid = 1'b0;
        lyr.rx_data  = 20'sd12345;
        step();
        chk("gap_rxr", lyr.rx_ready, 1);
        chk("gap_done", done, 0);
      end
      lyr.rx_valid = 1'b1;
      lyr.rx_data  = yexp[k];
      if (track) host_raddr = 3'(k);
      step();
      lyr.rx_valid = 1'b0;
      if (track) chk("rd_old", host_rdata, yold[k]);
    end
    chk("recv_done", done, 1);
    chk("recv_busy", busy, 0);
    chk("recv_rxr", lyr.rx_ready, 0);
    chk("recv_txv", lyr.tx_valid, 0);
  endtask

  task automatic readback();
    for (int k = 0; k < M; k++) begin
      host_raddr = 3'(k);
      step();
      chk("ybuf", host_rdata, yexp[k]);
    end
  endtask

  initial begin
    lyr.tx_ready = 1'b0;
    lyr.rx_valid = 1'b0;
    lyr.rx_data  = '0;
    for (int i = 0; i < N; i++) xexp[i] = 20'(i + 1);
    yexp[0] = -20'sd5;  yexp[1] = 20'sd0;   yexp[2] = 20'sd7;  yexp[3] = 20'sd12;
    yexp[4] = -20'sd33; yexp[5] = 20'sd64;  yexp[6] = -20'sd1; yexp[7] = 20'sd100;

    // Reset state
    step();
    step();
    chk_reset_outputs("rst");
    reset = 1'b1;

    // Load xbuf 1..8, last write coinciding with start
    for (int i = 0; i < N; i++) begin
      host_we    = 1'b1;
      host_waddr = 3'(i);
      host_wdata = xexp[i];
      if (i == N - 1) start = 1'b1;
      step();
    end
    host_we = 1'b0;
    start   = 1'b0;
    chk("run1_busy", busy, 1);

    // Run 1: peer always ready on tx, gapped rx
    send_all(-1, 0, 1'b0);
    recv_all(-1, 1'b0);
    host_raddr = 3'd2;
    step();
    chk("rd2", host_rdata, 7);
    readback();
    chk("done_hold", done, 1);

    // Run 2 from DONE: stall at idx 4, ignored start/write/rx_valid during SEND
    host_raddr = 3'd0;
    start_run();
    send_all(4, 3, 1'b1);
    chk("ybuf0_kept", host_rdata, -5);
    recv_all(-1, 1'b0);
    readback();

    // Run 3: reset while receiving at rx_cnt=3
    start_run();
    send_all(-1, 0, 1'b0);
    recv_all(3, 1'b0);
    reset        = 1'b0;
    lyr.rx_valid = 1'b1;
    lyr.rx_data  = 20'sd77;
    step();
    lyr.rx_valid = 1'b0;
    chk_reset_outputs("midrst");
    reset = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Run 4: resend from index 0, new extreme results, read-during-write of same entry
    for (int k = 0; k < M; k++) yold[k] = yexp[k];
    yexp[0] = 20'sd524287; yexp[1] = -20'sd524288; yexp[2] = 20'sd3;    yexp[3] = -20'sd7;
    yexp[4] = 20'sd1000;   yexp[5] = -20'sd1000;   yexp[6] = 20'sd42;   yexp[7] = -20'sd42;
    start_run();
    send_all(-1, 0, 1'b0);
    recv_all(-1, 1'b1);
    readback();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_driver_8_8_20.md
LAYER_DRIVER_8_8_20 -- requirements
Module: layer_driver_8_8_20

Interface
REQ-001 The block SHALL expose parameter N, default 8, number of input-vector words sent per run.
REQ-002 The block SHALL expose parameter M, default 8, number of result words received per run.
REQ-003 The block SHALL expose parameter T, default 20, signed word width.
REQ-004 The block SHALL expose parameters LOGN, default 3, and LOGM, default 3, as the index widths for N and M.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-007 start  input  1  one-cycle run request.
REQ-008 host_we  input  1  x-buffer write enable.
REQ-009 host_waddr  input  LOGN  x-buffer write index.
REQ-010 host_wdata  input  T signed  x-buffer write data.
REQ-011 host_raddr  input  LOGM  y-buffer read index.
REQ-012 host_rdata  output  T signed  y-buffer read data, registered.
REQ-013 busy  output  1  run in progress (SEND or RECV).
REQ-014 done  output  1  results available (DONE state).
REQ-015 tx_data  output  T signed  word to the layer data_in.
REQ-016 tx_valid  output  1  drives the layer s_valid.
REQ-017 tx_ready  input  1  from the layer s_ready.
REQ-018 rx_data  input  T signed  from the layer data_out.
REQ-019 rx_valid  input  1  from the layer m_valid.
REQ-020 rx_ready  output  1  drives the layer m_ready.

Function
REQ-021 The FSM SHALL have four states: IDLE, SEND, RECV and DONE.
REQ-022 In IDLE and DONE, host_we=1 SHALL write host_wdata to xbuf[host_waddr]; host_we SHALL be ignored in SEND and RECV.
REQ-023 start=1 in IDLE or DONE SHALL move the FSM to SEND with tx_idx=0, rx_cnt=0 and done=0 on the next cycle; start SHALL be ignored in SEND and RECV.
REQ-024 If start and host_we coincide in IDLE or DONE, the write SHALL complete and the run SHALL begin on the next cycle.
REQ-025 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal xbuf[tx_idx] combinationally from the registered tx_idx.
REQ-026 tx_valid SHALL NOT depend on tx_ready, so that the layer sees s_valid before it raises s_ready.
REQ-027 A transfer SHALL occur on each cycle with tx_valid and tx_ready both 1; each transfer SHALL increment tx_idx.
REQ-028 tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-029 The transfer at tx_idx==N-1 SHALL move the FSM to RECV on the next cycle; tx_valid SHALL be 0 outside SEND.
REQ-030 In RECV, rx_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-031 Each cycle with rx_valid and rx_ready both 1 SHALL write rx_data to ybuf[rx_cnt] and increment rx_cnt.
REQ-032 rx_valid SHALL be ignored outside RECV.
REQ-033 The accept at rx_cnt==M-1 SHALL move the FSM to DONE on the next cycle.
REQ-034 In DONE, done SHALL be 1 and SHALL hold until start.
REQ-035 busy SHALL be 1 exactly in SEND and RECV.
REQ-036 host_rdata SHALL update every cycle to ybuf[host_raddr], with 1-cycle latency; ybuf SHALL be readable in every state.
REQ-037 A read and a write of the same ybuf entry in the same cycle SHALL return the old value.
REQ-038 The block SHALL pass data through unmodified, with no arithmetic and no saturation.
REQ-039 Minimum run latency SHALL be 1+N+M cycles from start to done=1 when the peer is always ready.

Reset
REQ-040 With reset==0 at a rising edge, the block SHALL enter IDLE with tx_idx=0, rx_cnt=0, tx_valid=0, rx_ready=0, busy=0, done=0 and host_rdata=0.
REQ-041 xbuf and ybuf contents SHALL NOT be cleared by reset.
REQ-042 Reset mid-run SHALL abort the run; the next start SHALL resend from index 0.

Verification
REQ-043 Load xbuf with 1..8, pulse start, hold tx_ready=1 -> tx_data sequence 1..8 on 8 consecutive cycles, then rx_ready=1.
REQ-044 Hold tx_ready=0 for 3 cycles at tx_idx=4 -> tx_valid stays 1, tx_data stays 5, and 8 transfers total.
REQ-045 Feed rx_data -5,0,7,...,100 with rx_valid gaps -> ybuf holds the 8 values in order, done=1 one cycle after the 8th accept, host_raddr=2 returns 7 one cycle later.
REQ-046 Pulse start and host_we during SEND, and rx_valid during SEND -> no effect on the run, xbuf or ybuf.
REQ-047 Assert reset==0 during RECV at rx_cnt=3 -> IDLE next cycle with all outputs at reset values; the next start resends xbuf[0] first.
REQ-048 Pulse start in DONE -> done=0 and SEND on the next cycle, with a back-to-back run producing identical results.
